fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side drain stage that sits directly downstream of the synchronous FIFO. It pulls words from the FIFO's read port (rd_en / data_out / empty) and presents them on a valid/ready stream to the next consumer. It hides the FIFO's one-cycle read latency with a 2-entry output buffer, so it can sustain one word per clock under continuous ready and loses no data under backpressure.

## Interface
- FIFO_WIDTH, 16, data word width; must match the FIFO.
- CNT_WIDTH, 16, width of the transferred-word counter (stats build only).

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag; reflects FIFO state after the most recent edge.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- fifo_underflow  in  1  FIFO underflow flag; high the cycle after a read was attempted on an empty FIFO.
- fifo_rd_en  out  1  read request to the FIFO.
- m_data  out  FIFO_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  consumer ready; a transfer occurs when m_valid && m_ready at a rising edge.
- busy  out  1  high when the buffer holds data or a read is in flight.
- clear_stats  in  1  synchronous clear of the stats (stats build only).
- word_count  out  CNT_WIDTH  number of completed stream transfers (stats build only).
- underflow_err  out  1  sticky underflow error (stats build only).

## Operation
- State:
  - occ: buffer occupancy, 0..2.
  - inflight: registered copy of fifo_rd_en from the previous cycle.
  - Two data slots, head and tail.
- pop = m_valid && m_ready.
- fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2.
  - Combinational, with no combinational path from m_data.
  - This guarantees every in-flight word has a free slot.
- Capture: if inflight is 1 and fifo_underflow is 0 in a cycle, fifo_data_out is written into the buffer at the end of that cycle.
  - The word goes into head if the buffer is empty after the pop, otherwise into tail.
- Pop: head takes the value of tail, and occ decrements.
  - Simultaneous pop and capture keeps occ unchanged; the captured word lands behind any remaining entry.
- m_valid = (occ != 0); m_data = head. Both are driven directly from registers.
- Order is strictly FIFO; no word is ever dropped or duplicated.
- Underflow: if inflight is 1 and fifo_underflow is 1, the capture is discarded and occ is unchanged.
- busy = (occ != 0) || inflight.
- Arithmetic: occ + inflight is evaluated at 3 bits with no wrap; occ saturates at 0 and 2 by construction.

## Timing
- Reset (async assert, sync-safe release) sets the following, and any in-flight read is forgotten:
  - fifo_rd_en=0, m_valid=0, m_data=0, busy=0
  - occ=0, inflight=0
  - word_count=0, underflow_err=0
- Latency with an idle buffer:
  - Cycle t: fifo_empty falls, fifo_rd_en=1.
  - Cycle t+1: data captured.
  - Cycle t+2: m_valid=1.
- Throughput is 1 word/clk while m_ready=1 and the FIFO is non-empty.
- Backpressure:
  - m_data and m_valid hold stable while m_valid && !m_ready.
  - fifo_rd_en drops in the cycle where occ + inflight - pop reaches 2.
- fifo_empty high stops reads in the same cycle; an in-flight word is still captured.
- Reset mid-transfer: buffered and in-flight words are lost, and the FIFO must be reset with the same rst_n.

## Configuration
- Macro FIFO_STREAM_STATS_EN.
- Defined:
  - word_count increments by 1 on each pop and wraps modulo 2^CNT_WIDTH.
  - underflow_err sets on a discarded capture and stays set until clear_stats or reset.
  - clear_stats zeroes both; a pop in the same cycle is not counted.
- Undefined:
  - The clear_stats, word_count and underflow_err ports and their logic are absent.
  - Underflow captures are still discarded.

## Test plan
- Reset: assert rst_n=0 with occ=2 and inflight=1 -> fifo_rd_en, m_valid, m_data, busy and stats are 0 immediately; no m_valid after release until new data arrives.
- Single word: FIFO holds 0xA5A5, m_ready=1 -> fifo_rd_en high exactly in cycle 0; m_valid high in cycle 2 only, with m_data=0xA5A5.
- Streaming: FIFO holds 0x0001..0x0008, m_ready=1 -> fifo_rd_en high in cycles 0-7; m_valid high in cycles 2-9, carrying 0x0001..0x0008 in order.
- Backpressure: same load, m_ready=0 from cycle 3 to cycle 10 -> fifo_rd_en low once occ+inflight=2; m_data held; all 8 words are delivered in order after m_ready returns.
- Underflow: force fifo_underflow=1 in the cycle after a read -> no capture, occ unchanged, underflow_err=1 (stats build).
- Stats: 5 transfers -> word_count=5; pulse clear_stats -> word_count=0 and underflow_err=0 on the next cycle.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO onto a valid/ready stream.
// A 2-entry head/tail buffer absorbs the FIFO's one-cycle read latency so
// the stage sustains one word per clock and never drops data under
// backpressure. Optional statistics (word counter, sticky underflow flag)
// are built only when FIFO_STREAM_STATS_EN is defined.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_STREAM_STATS_EN
  ,
  input  logic                  clear_stats,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  underflow_err
`endif
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic                  pop;
  logic                  capture;
  logic                  discard;
  logic [2:0]            pend;
  logic [1:0]            occ_left;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;
  assign pop     = m_valid && m_ready;
  assign capture = inflight_q && !fifo_underflow;
  assign discard = inflight_q && fifo_underflow;
  assign busy    = m_valid || inflight_q;

  // Words owned after this cycle's pop; pop implies occ>=1 so no wrap.
  assign pend = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Only request a word when a slot is guaranteed for it; held low in reset.
  assign fifo_rd_en = rst_n && !fifo_empty && (pend < 3'd2);

  // Buffer next state: pop shifts tail to head, capture lands behind survivors.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    occ_left = occ_q - {1'b0, pop};
    if (pop) head_d = tail_q;
    if (capture) begin
      if (occ_left == 2'd0) head_d = fifo_data_out;
      else                  tail_d = fifo_data_out;
    end
    occ_d = occ_left + {1'b0, capture};
  end

  // Buffer and in-flight tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef FIFO_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] word_count_q, word_count_d;
  logic                 underflow_err_q, underflow_err_d;

  assign word_count    = word_count_q;
  assign underflow_err = underflow_err_q;

  // Stats next state: clear wins over a same-cycle pop or discard.
  always_comb begin
    word_count_d    = word_count_q;
    underflow_err_d = underflow_err_q;
    if (clear_stats) begin
      word_count_d    = '0;
      underflow_err_d = 1'b0;
    end else begin
      if (pop)     word_count_d    = word_count_q + 1'b1;
      if (discard) underflow_err_d = 1'b1;
    end
  end

  // Stats registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_q    <= '0;
      underflow_err_q <= 1'b0;
    end else begin
      word_count_q    <= word_count_d;
      underflow_err_q <= underflow_err_d;
    end
  end
`else
  // Keeps the counter width parameter referenced in the lean build.
  logic [CNT_WIDTH-1:0] cnt_width_unused;
  logic                 discard_unused;
  assign cnt_width_unused = '0;
  assign discard_unused   = discard;
`endif

endmodule
